// File: rtl/value_history.sv
// -----------------------------------------------------------------------------
// value_history
//
// History buffer for the random-number lab datapath. It keeps the last DEPTH
// accepted values for the HEX displays. entry[0] is the newest value. A browse
// cursor steps through older entries using debounced key pulses.
//
// Parameters:
//   WIDTH  bit width of each stored value
//   DEPTH  number of history entries (2..64)
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_clear         synchronous clear of the whole history
//   i_push          capture i_data as the newest entry
//   i_data          value to record
//   i_browse_older  move the cursor one entry older
//   i_browse_newer  move the cursor one entry newer
//   o_latest        entry[0]
//   o_prev          entry[1]
//   o_browse_data   entry[cursor], a combinational mux
//   o_browse_idx    cursor position, 0 = newest
//   o_count         number of valid entries, 0..DEPTH
//   o_full          high when o_count == DEPTH
//
// Build option:
//   VALUE_HISTORY_DEDUP_EN  when defined, a push is rejected if it repeats the
//                           newest stored value and history is not empty.
// -----------------------------------------------------------------------------
module value_history #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_browse_older,
    input  logic                       i_browse_newer,
    output logic [WIDTH-1:0]           o_latest,
    output logic [WIDTH-1:0]           o_prev,
    output logic [WIDTH-1:0]           o_browse_data,
    output logic [$clog2(DEPTH)-1:0]   o_browse_idx,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [IDX_W-1:0] cursor_q;
    logic [CNT_W-1:0] count_q;
    logic             full_q;

    logic push_ok;
    logic can_older;
    logic can_newer;

`ifdef VALUE_HISTORY_DEDUP_EN
    // A repeat of the newest value is ignored, but an empty history always
    // accepts its first value.
    assign push_ok = i_push && ((count_q == '0) || (i_data != entry_q[0]));
`else
    assign push_ok = i_push;
`endif

    // The cursor may advance only while it stays below the last valid entry.
    // When the history is empty this is never true, so the cursor stays at 0.
    assign can_older = (CNT_W'(cursor_q) + CNT_W'(1)) < count_q;
    assign can_newer = (cursor_q != '0);

    // NOTE: the storage is a register array and not a RAM. The reset loop
    // below is intentional. Entries past o_count must read 0 without masking
    // logic, and a RAM macro could not clear every entry in one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) entry_q[k] <= '0;
            cursor_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else if (i_clear) begin
            // A push in the same cycle is dropped on purpose.
            for (int k = 0; k < DEPTH; k++) entry_q[k] <= '0;
            cursor_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else if (push_ok) begin
            // NOTE: non-blocking assignments make every stage read its
            // neighbour's old value, so the loop order does not matter.
            for (int k = DEPTH - 1; k > 0; k--) entry_q[k] <= entry_q[k-1];
            entry_q[0] <= i_data;
            if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
            full_q   <= (count_q >= CNT_W'(DEPTH - 1));
            cursor_q <= '0;
        end else if (i_browse_older && !i_browse_newer && can_older) begin
            cursor_q <= cursor_q + IDX_W'(1);
        end else if (i_browse_newer && !i_browse_older && can_newer) begin
            cursor_q <= cursor_q - IDX_W'(1);
        end
    end

    assign o_latest      = entry_q[0];
    assign o_prev        = entry_q[1];
    assign o_browse_data = entry_q[cursor_q];
    assign o_browse_idx  = cursor_q;
    assign o_count       = count_q;
    assign o_full        = full_q;

endmodule
